// File: rtl/snitch_demux_credit.sv
// N-port request arbiter with credit limits and in-order response routing through split read/write order FIFOs.
// Optional stall counters are built when SNITCH_DEMUX_CREDIT_PERF_EN is defined.
module snitch_demux_credit #(
  parameter int unsigned NrPorts        = 4,
  parameter int unsigned ReqWidth       = 64,
  parameter int unsigned RespWidth      = 32,
  parameter int unsigned RespDepth      = 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          RoundRobin     = 1'b1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
`ifdef SNITCH_DEMUX_CREDIT_PERF_EN
  input  logic                                          perf_clear_i,
  output logic [NrPorts*32-1:0]                         stall_cnt_o,
`endif
  input  logic [NrPorts*ReqWidth-1:0]                   req_payload_i,
  input  logic [NrPorts-1:0]                            req_write_i,
  input  logic [NrPorts-1:0]                            req_valid_i,
  output logic [NrPorts-1:0]                            req_ready_o,
  output logic [NrPorts*RespWidth-1:0]                  resp_payload_o,
  output logic [NrPorts-1:0]                            resp_last_o,
  output logic [NrPorts-1:0]                            resp_valid_o,
  input  logic [NrPorts-1:0]                            resp_ready_i,
  output logic [ReqWidth-1:0]                           req_payload_o,
  output logic                                          req_write_o,
  output logic                                          req_valid_o,
  input  logic                                          req_ready_i,
  input  logic [RespWidth-1:0]                          resp_payload_i,
  input  logic                                          resp_write_i,
  input  logic                                          resp_last_i,
  input  logic                                          resp_valid_i,
  output logic                                          resp_ready_o,
  output logic [NrPorts*$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                          err_o
);

  localparam int unsigned IdxW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = $clog2(RespDepth);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   fill_t;

  // Order FIFOs: index 0 tracks reads, index 1 tracks writes.
  idx_t  fifo_mem_q [2][RespDepth];
  ptr_t  wr_ptr_q [2], wr_ptr_d [2];
  ptr_t  rd_ptr_q [2], rd_ptr_d [2];
  fill_t fill_q [2], fill_d [2];
  logic  fifo_full [2];
  logic  fifo_push [2];
  logic  fifo_pop [2];

  cnt_t  cnt_q [NrPorts], cnt_d [NrPorts];
  idx_t  rr_ptr_q, rr_ptr_d;
  logic  lock_q, lock_d;
  idx_t  lock_idx_q, lock_idx_d;
  logic  err_q, err_d;

  logic [NrPorts-1:0] elig;
  logic               arb_found;
  idx_t               arb_idx;
  idx_t               grant_idx;
  logic               grant_vld;
  logic               req_hs;

  logic               resp_sel;
  idx_t               head_idx;
  logic               resp_err;
  logic               resp_pop;

  always_comb begin
    for (int f = 0; f < 2; f++) begin
      fifo_full[f] = (fill_q[f] == fill_t'(RespDepth));
    end
  end

  // Request arbitration: eligibility, search and lock override
  always_comb begin
    int j;
    int start;
    elig      = '0;
    arb_found = 1'b0;
    arb_idx   = '0;
    j         = 0;
    start     = RoundRobin ? int'(rr_ptr_q) : 0;
    for (int i = 0; i < int'(NrPorts); i++) begin
      elig[i] = req_valid_i[i] && (cnt_q[i] < cnt_t'(MaxOutstanding))
                && !(req_write_i[i] ? fifo_full[1] : fifo_full[0]);
    end
    for (int k = 0; k < int'(NrPorts); k++) begin
      j = start + k;
      if (j >= int'(NrPorts)) j = j - int'(NrPorts);
      if (!arb_found && elig[j]) begin
        arb_found = 1'b1;
        arb_idx   = idx_t'(j);
      end
    end
    grant_idx = lock_q ? lock_idx_q : arb_idx;
    grant_vld = !rst_i && (lock_q ? req_valid_i[lock_idx_q] : arb_found);
    req_hs    = grant_vld && req_ready_i;
  end

  always_comb begin
    req_valid_o   = grant_vld;
    req_payload_o = req_payload_i[int'(grant_idx)*ReqWidth +: ReqWidth];
    req_write_o   = req_write_i[grant_idx];
    req_ready_o   = '0;
    if (grant_vld) req_ready_o[grant_idx] = req_ready_i;
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    if (req_hs) begin
      lock_d   = 1'b0;
      rr_ptr_d = (int'(grant_idx) == int'(NrPorts) - 1) ? '0 : grant_idx + idx_t'(1);
    end else if (grant_vld) begin
      lock_d     = 1'b1;
      lock_idx_d = grant_idx;
    end
  end

  // Response routing: the head of the selected order FIFO owns the beat
  always_comb begin
    resp_sel       = resp_write_i;
    head_idx       = fifo_mem_q[resp_sel][rd_ptr_q[resp_sel]];
    resp_err       = resp_valid_i
                     && ((fill_q[resp_sel] == '0) || (resp_last_i && (cnt_q[head_idx] == '0)));
    resp_valid_o   = '0;
    if (resp_valid_i && !resp_err && !rst_i) resp_valid_o[head_idx] = 1'b1;
    resp_ready_o   = resp_err ? 1'b1 : resp_ready_i[head_idx];
    resp_pop       = resp_valid_i && !resp_err && resp_ready_i[head_idx] && resp_last_i;
    resp_payload_o = {NrPorts{resp_payload_i}};
    resp_last_o    = {NrPorts{resp_last_i}};
    err_d          = err_q | resp_err;
  end

  always_comb begin
    fifo_push[0] = req_hs && !req_write_o;
    fifo_push[1] = req_hs && req_write_o;
    fifo_pop[0]  = resp_pop && !resp_write_i;
    fifo_pop[1]  = resp_pop && resp_write_i;
    for (int f = 0; f < 2; f++) begin
      wr_ptr_d[f] = wr_ptr_q[f] + ptr_t'(fifo_push[f]);
      rd_ptr_d[f] = rd_ptr_q[f] + ptr_t'(fifo_pop[f]);
      fill_d[f]   = fill_q[f] + fill_t'(fifo_push[f]) - fill_t'(fifo_pop[f]);
    end
  end

  // A same-port issue and retire in one cycle cancel out
  always_comb begin
    for (int i = 0; i < int'(NrPorts); i++) begin
      cnt_d[i] = cnt_q[i];
      if (req_hs && (int'(grant_idx) == i)) cnt_d[i] = cnt_d[i] + cnt_t'(1);
      if (resp_pop && (int'(head_idx) == i)) cnt_d[i] = cnt_d[i] - cnt_t'(1);
      outstanding_o[i*CntW +: CntW] = cnt_q[i];
    end
  end

  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int f = 0; f < 2; f++) begin
        wr_ptr_q[f] <= '0;
        rd_ptr_q[f] <= '0;
        fill_q[f]   <= '0;
      end
      for (int i = 0; i < int'(NrPorts); i++) cnt_q[i] <= '0;
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int f = 0; f < 2; f++) begin
        wr_ptr_q[f] <= wr_ptr_d[f];
        rd_ptr_q[f] <= rd_ptr_d[f];
        fill_q[f]   <= fill_d[f];
      end
      for (int i = 0; i < int'(NrPorts); i++) cnt_q[i] <= cnt_d[i];
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage carries no reset; validity comes from the fill counters
  always_ff @(posedge clk_i) begin
    for (int f = 0; f < 2; f++) begin
      if (!rst_i && fifo_push[f]) fifo_mem_q[f][wr_ptr_q[f]] <= grant_idx;
    end
  end

`ifdef SNITCH_DEMUX_CREDIT_PERF_EN
  logic [31:0] stall_q [NrPorts], stall_d [NrPorts];

  always_comb begin
    for (int i = 0; i < int'(NrPorts); i++) begin
      stall_d[i] = stall_q[i];
      if (perf_clear_i) stall_d[i] = '0;
      else if (req_valid_i[i] && !req_ready_o[i] && (stall_q[i] != '1)) stall_d[i] = stall_q[i] + 32'd1;
      stall_cnt_o[i*32 +: 32] = stall_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NrPorts); i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NrPorts); i++) stall_q[i] <= stall_d[i];
    end
  end
`endif

endmodule
